// File: rtl/spi_master_control.sv
// Mode-0 SPI master: one MSB-first DATA_LENGTH-bit frame per SS assertion, SCLK = clk/(2*CLK_DIV).
// Every output is registered; start is only honoured in IDLE and is otherwise dropped.
module spi_master_control #(
   parameter int DATA_LENGTH = 8,
   parameter int CLK_DIV     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [DATA_LENGTH-1:0] data_to_slave,
   output logic [DATA_LENGTH-1:0] data_from_slave,
   output logic                   busy,
   output logic                   done,
   output logic                   SCLK,
   output logic                   SS,
   output logic                   MOSI,
   input  logic                   MISO
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(DATA_LENGTH + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_LENGTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_XFER_HI,
      S_XFER_LO,
      S_TRAIL,
      S_GAP
   } state_t;

   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [BW-1:0]          r_bit;
   logic [DATA_LENGTH-1:0] r_tx;
   logic [DATA_LENGTH-1:0] r_rx;
   logic                   w_hold_end;

   assign w_hold_end = (r_cnt == HOLD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_bit           <= '0;
         r_tx            <= '0;
         r_rx            <= '0;
         data_from_slave <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         SCLK            <= 1'b0;
         SS              <= 1'b1;
         MOSI            <= 1'b0;
      end else begin
         done <= 1'b0;
         // Every non-idle state lasts exactly CLK_DIV cycles; the counter restarts on each exit.
         if (r_state != S_IDLE) begin
            r_cnt <= w_hold_end ? '0 : r_cnt + CW'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_tx    <= data_to_slave;
                  SS      <= 1'b0;
                  MOSI    <= data_to_slave[DATA_LENGTH-1];
                  busy    <= 1'b1;
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= S_LEAD;
               end
            end
            S_LEAD: begin
               if (w_hold_end) begin
                  SCLK    <= 1'b1;
                  r_rx    <= {r_rx[DATA_LENGTH-2:0], MISO};
                  r_state <= S_XFER_HI;
               end
            end
            S_XFER_HI: begin
               if (w_hold_end) begin
                  SCLK  <= 1'b0;
                  r_bit <= r_bit + BW'(1);
                  if (r_bit != LAST_BIT) begin
                     r_tx    <= r_tx << 1;
                     MOSI    <= r_tx[DATA_LENGTH-2];
                     r_state <= S_XFER_LO;
                  end else begin
                     MOSI    <= 1'b0;
                     r_state <= S_TRAIL;
                  end
               end
            end
            S_XFER_LO: begin
               if (w_hold_end) begin
                  SCLK    <= 1'b1;
                  r_rx    <= {r_rx[DATA_LENGTH-2:0], MISO};
                  r_state <= S_XFER_HI;
               end
            end
            S_TRAIL: begin
               if (w_hold_end) begin
                  SS              <= 1'b1;
                  data_from_slave <= r_rx;
                  done            <= 1'b1;
                  r_state         <= S_GAP;
               end
            end
            S_GAP: begin
               if (w_hold_end) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_control.sv
// Bench for spi_master_control: two instances (CLK_DIV=4 and CLK_DIV=1) against a timing model
// that derives every output from the cycle offset since start acceptance.
module tb_spi_master_control;

   localparam int DL = 8;

   logic       clk;
   logic       rst;
   logic       start_v [2];
   logic [7:0] dts     [2];
   logic       loop;
   logic [7:0] stx;

   logic [7:0] dfs0, dfs1;
   logic       busy0, done0, sclk0, ss0, mosi0, miso0;
   logic       busy1, done1, sclk1, ss1, mosi1, miso1;
   logic       slave_miso;

   assign miso0 = loop ? mosi0 : slave_miso;
   assign miso1 = mosi1;

   spi_master_control #(.DATA_LENGTH(8), .CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start_v[0]), .data_to_slave(dts[0]),
      .data_from_slave(dfs0), .busy(busy0), .done(done0),
      .SCLK(sclk0), .SS(ss0), .MOSI(mosi0), .MISO(miso0)
   );

   spi_master_control #(.DATA_LENGTH(8), .CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .data_to_slave(dts[1]),
      .data_from_slave(dfs1), .busy(busy1), .done(done1),
      .SCLK(sclk1), .SS(ss1), .MOSI(mosi1), .MISO(miso1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Mode-0 slave: shifts out after each SCLK fall, captures MOSI after each rise.
   int         fcnt = 0;
   logic       sprev = 1'b0;
   logic [7:0] srx = 8'h00;
   always @(negedge clk) begin
      if (ss0) begin
         fcnt = 0;
      end else begin
         if (sclk0 && !sprev) srx = {srx[6:0], mosi0};
         if (!sclk0 && sprev) fcnt++;
      end
      sprev = sclk0;
      slave_miso = (fcnt < 8) ? stx[7-fcnt] : 1'b0;
   end

   // Reference model: state is just "frame active", offset n since t0, words.
   logic       m_act [2];
   int         m_n   [2];
   logic [7:0] m_tx  [2];
   logic [7:0] m_rx  [2];
   logic [7:0] m_dfs [2];

   function automatic int cd_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_act[i] = 1'b0;
            m_dfs[i] = 8'h00;
         end else if (m_act[i]) begin
            m_n[i]++;
            if ((m_n[i] % cd_of(i) == 0) && ((m_n[i] / cd_of(i)) % 2 == 1) && (m_n[i] / cd_of(i) < 2*DL))
               m_rx[i] = {m_rx[i][6:0], (i == 0) ? miso0 : miso1};
            if (m_n[i] == (2*DL+1)*cd_of(i)) m_dfs[i] = m_rx[i];
            if (m_n[i] == (2*DL+2)*cd_of(i)) m_act[i] = 1'b0;
         end else if (start_v[i]) begin
            m_act[i] = 1'b1;
            m_n[i]   = 0;
            m_tx[i]  = dts[i];
         end
      end
   end

   // {SS, SCLK, MOSI, busy, done, data_from_slave}
   function automatic logic [12:0] expv(input int i);
      int   n, cd, h;
      logic ss, sc, mo, dn;
      if (!m_act[i]) return {1'b1, 4'b0000, m_dfs[i]};
      n  = m_n[i];
      cd = cd_of(i);
      h  = n / cd;
      ss = (n >= (2*DL+1)*cd);
      sc = (h % 2 == 1) && (h < 2*DL);
      mo = (h < 2*DL) ? m_tx[i][DL-1-h/2] : 1'b0;
      dn = (n == (2*DL+1)*cd);
      return {ss, sc, mo, 1'b1, dn, m_dfs[i]};
   endfunction

   int total = 0;
   int bad   = 0;
   int t0, t1;
   int done_cnt, done_cyc, done1_cyc, rises, ss_rise, min_gap;
   logic p_sclk, p_ss;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic kick0(input logic [7:0] d);
      @(negedge clk);
      dts[0] = d;
      start_v[0] = 1'b1;
      t0 = cyc + 1;
      @(negedge clk);
      start_v[0] = 1'b0;
   endtask

   task automatic wait_idle0();
      int k = 0;
      while (busy0 === 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) chk("busy0_timeout", busy0, 0);
   endtask

   task automatic wait_idle1();
      int k = 0;
      while (busy1 === 1'b1 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) chk("busy1_timeout", busy1, 0);
   endtask

   task automatic wait_done(input int n);
      int k = 0;
      while (done_cnt < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("done_count_reached", done_cnt, n);
   endtask

   initial begin
      rst = 1'b1;
      start_v[0] = 1'b0; start_v[1] = 1'b0;
      dts[0] = 8'h00; dts[1] = 8'h00;
      loop = 1'b1;
      stx = 8'h00;
      done_cnt = 0; done_cyc = 0; done1_cyc = 0; rises = 0;
      ss_rise = 0; min_gap = 100000;
      p_sclk = 1'b0; p_ss = 1'b1;
      fork
         forever begin
            @(posedge clk);
            #1;
            chk("dut0_outputs", {ss0, sclk0, mosi0, busy0, done0, dfs0}, expv(0));
            chk("dut1_outputs", {ss1, sclk1, mosi1, busy1, done1, dfs1}, expv(1));
            if (done0) begin done_cnt++; done_cyc = cyc; end
            if (done1) done1_cyc = cyc;
            if (sclk0 && !p_sclk) rises++;
            if (ss0 && !p_ss) ss_rise = cyc;
            if (!ss0 && p_ss && (cyc - ss_rise) < min_gap) min_gap = cyc - ss_rise;
            p_sclk = sclk0;
            p_ss = ss0;
         end
         begin
            repeat (3) @(negedge clk);
            chk("reset_ss", ss0, 1);
            chk("reset_sclk", sclk0, 0);
            chk("reset_busy", busy0, 0);
            chk("reset_dfs", dfs0, 0);
            rst = 1'b0;

            // Loopback 0xA5
            rises = 0; done_cnt = 0;
            kick0(8'hA5);
            wait_idle0();
            chk("a5_done_time", done_cyc - t0, 68);
            chk("a5_dfs", dfs0, 8'hA5);
            chk("a5_rises", rises, 8);
            chk("a5_done_pulses", done_cnt, 1);

            // Slave returns 0x3C while master sends 0xC3
            loop = 1'b0; stx = 8'h3C;
            kick0(8'hC3);
            wait_idle0();
            chk("slave_captured", srx, 8'hC3);
            chk("slave_dfs", dfs0, 8'h3C);

            // Back-to-back frames with start held
            loop = 1'b1; done_cnt = 0; min_gap = 100000;
            @(negedge clk);
            dts[0] = 8'h01; start_v[0] = 1'b1;
            wait_done(1);
            chk("b2b_word1", dfs0, 8'h01);
            dts[0] = 8'h80;
            wait_done(2);
            chk("b2b_word2", dfs0, 8'h80);
            dts[0] = 8'hFF;
            wait_done(3);
            chk("b2b_word3", dfs0, 8'hFF);
            start_v[0] = 1'b0;
            wait_idle0();
            chk("b2b_min_gap_ok", min_gap >= 5, 1);
            chk("b2b_done_pulses", done_cnt, 3);

            // start during a frame is dropped
            done_cnt = 0;
            kick0(8'h69);
            while (cyc < t0 + 19) @(negedge clk);
            dts[0] = 8'h55; start_v[0] = 1'b1;
            @(negedge clk);
            start_v[0] = 1'b0;
            wait_idle0();
            repeat (3) @(negedge clk);
            chk("ignored_start_dfs", dfs0, 8'h69);
            chk("ignored_start_pulses", done_cnt, 1);
            chk("ignored_start_idle", busy0, 0);

            // Reset mid-frame
            kick0(8'h3E);
            while (cyc < t0 + 29) @(negedge clk);
            rst = 1'b1;
            #1;
            chk("midrst_ss", ss0, 1);
            chk("midrst_sclk", sclk0, 0);
            chk("midrst_busy", busy0, 0);
            chk("midrst_dfs", dfs0, 0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            kick0(8'h96);
            wait_idle0();
            chk("after_rst_dfs", dfs0, 8'h96);

            // CLK_DIV=1 loopback
            @(negedge clk);
            dts[1] = 8'h5A; start_v[1] = 1'b1; t1 = cyc + 1;
            @(negedge clk);
            start_v[1] = 1'b0;
            wait_idle1();
            chk("div1_done_time", done1_cyc - t1, 17);
            chk("div1_dfs", dfs1, 8'h5A);

            // Randomized frames on both instances
            for (int it = 0; it < 25; it++) begin
               logic [7:0] d, d1;
               d = 8'($urandom);
               d1 = 8'($urandom);
               loop = 1'($urandom_range(0, 1));
               stx = 8'($urandom);
               @(negedge clk);
               dts[0] = d; dts[1] = d1;
               start_v[0] = 1'b1; start_v[1] = 1'b1;
               @(negedge clk);
               start_v[0] = 1'b0; start_v[1] = 1'b0;
               dts[0] = 8'($urandom); dts[1] = 8'($urandom);
               if ($urandom_range(0, 1) == 1) begin
                  repeat ($urandom_range(1, 50)) @(negedge clk);
                  dts[0] = 8'($urandom);
                  start_v[0] = 1'b1;
                  @(negedge clk);
                  start_v[0] = 1'b0;
               end
               wait_idle0();
               wait_idle1();
               chk("rand_dfs0", dfs0, loop ? d : stx);
               chk("rand_dfs1", dfs1, d1);
               if (!loop) chk("rand_slave_rx", srx, d);
               repeat ($urandom_range(0, 5)) @(negedge clk);
            end
         end
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
